// File: rtl/hamming_uart_framer_pkg.sv
// Shared types and Hamming position helpers for the Hamming-coded UART framer.
package hamming_uart_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int HAM_POS_P1  = 1;
    localparam int HAM_POS_P2  = 2;
    localparam int HAM_POS_P4  = 4;
    localparam int HAM_POS_P8  = 8;
    localparam int HAM_MAX_POS = 15;

    function automatic int ham_code_w(input int data_w);
        return (data_w == 11) ? 15 : 7;
    endfunction

    function automatic int ham_parity_cnt(input int data_w);
        return (data_w == 11) ? 4 : 3;
    endfunction

    function automatic int ham_parity_pos(input int k);
        case (k)
            0:       return HAM_POS_P1;
            1:       return HAM_POS_P2;
            2:       return HAM_POS_P4;
            default: return HAM_POS_P8;
        endcase
    endfunction

    function automatic logic ham_is_parity_pos(input int pos);
        return (pos == HAM_POS_P1) || (pos == HAM_POS_P2) ||
               (pos == HAM_POS_P4) || (pos == HAM_POS_P8);
    endfunction

    // Position (1-based) occupied by data bit idx: the idx-th non-parity slot.
    function automatic int ham_data_pos(input int idx);
        int seen;
        int res;
        seen = 0;
        res  = 0;
        for (int pos = 1; pos <= HAM_MAX_POS; pos++) begin
            if (!ham_is_parity_pos(pos)) begin
                if (seen == idx) begin
                    res = pos;
                end
                seen = seen + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_uart_framer_fifo.sv
// Small synchronous FIFO for encoded words; full/empty are registered flags.
module hamming_sync_fifo
    import hamming_uart_framer_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push into a full FIFO is still accepted when a pop frees a slot this cycle
    always_comb begin
        pop_ok_s  = pop && !empty_r;
        push_ok_s = push && (!full_r || pop_ok_s);
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array, data path only
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/hamming_uart_framer.sv
// Hamming-encodes payloads on start edges, queues them and sends each as a UART frame.
module hamming_uart_framer
    import hamming_uart_framer_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow,
    output logic [7:0]        frame_cnt
);
    localparam int CODE_W = ham_code_w(DATA_W);
    localparam int NPAR   = ham_parity_cnt(DATA_W);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(CODE_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CODE_W - 1);

    function automatic logic [CODE_W-1:0] ham_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              p;
        c = {CODE_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            c[ham_data_pos(i) - 1] = d[i];
        end
        for (int k = 0; k < NPAR; k++) begin
            p = 1'b0;
            for (int b = 0; b < CODE_W; b++) begin
                if ((((b + 1) >> k) % 2) == 1) begin
                    p = p ^ c[b];
                end
            end
            c[ham_parity_pos(k) - 1] = p;
        end
        return c;
    endfunction

    function automatic logic even_par(input logic [CODE_W-1:0] w);
        return ^w;
    endfunction

    tx_state_t         state_r;
    logic [BAUD_W-1:0] baud_r;
    logic [BIT_W-1:0]  bit_idx_r;
    logic [CODE_W-1:0] shift_r;
    logic              parity_r;
    logic              tx_r;
    logic              busy_r;
    logic              overflow_r;
    logic [7:0]        frame_cnt_r;
    logic              start_d_r;
    logic              armed_r;
    logic              strobe_s;
    logic              pop_s;
    logic              baud_done_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CODE_W-1:0] code_s;
    logic [CODE_W-1:0] fifo_rdata_s;

    assign strobe_s    = start && !start_d_r && armed_r;
    assign code_s      = ham_encode(data_in);
    assign baud_done_s = (baud_r == BAUD_LAST);

    // Head of queue is taken when idle, or at the end of STOP for back-to-back frames
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_STOP: pop_s = baud_done_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    hamming_sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (strobe_s),
        .pop   (pop_s),
        .wdata (code_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Start edge detect (a level already high at reset release never counts) and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d_r  <= 1'b0;
            armed_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            start_d_r <= start;
            armed_r   <= armed_r || !start;
            if (strobe_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Transmit sequencer; tx and busy follow the state one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            baud_r      <= BAUD_W'(0);
            bit_idx_r   <= BIT_W'(0);
            shift_r     <= {CODE_W{1'b0}};
            parity_r    <= 1'b0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            busy_r <= (state_r != ST_IDLE) || !fifo_empty_s;
            case (state_r)
                ST_START:  tx_r <= 1'b0;
                ST_DATA:   tx_r <= shift_r[0];
                ST_PARITY: tx_r <= parity_r;
                default:   tx_r <= 1'b1;
            endcase
            case (state_r)
                ST_IDLE: begin
                    baud_r    <= BAUD_W'(0);
                    bit_idx_r <= BIT_W'(0);
                    if (pop_s) begin
                        shift_r  <= fifo_rdata_s;
                        parity_r <= even_par(fifo_rdata_s);
                        state_r  <= ST_START;
                    end
                end
                ST_START, ST_PARITY: begin
                    if (baud_done_s) begin
                        baud_r  <= BAUD_W'(0);
                        state_r <= (state_r == ST_START) ? ST_DATA : ST_STOP;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done_s) begin
                        baud_r  <= BAUD_W'(0);
                        shift_r <= {1'b0, shift_r[CODE_W-1:1]};
                        if (bit_idx_r == BIT_LAST) begin
                            bit_idx_r <= BIT_W'(0);
                            state_r   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done_s) begin
                        baud_r      <= BAUD_W'(0);
                        frame_cnt_r <= frame_cnt_r + 8'd1;
                        if (pop_s) begin
                            shift_r  <= fifo_rdata_s;
                            parity_r <= even_par(fifo_rdata_s);
                            state_r  <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign tx        = tx_r;
    assign busy      = busy_r;
    assign fifo_full = fifo_full_s;
    assign overflow  = overflow_r;
    assign frame_cnt = frame_cnt_r;

endmodule
